mips_mmio_bridge: RTL and testbench

MIPS_MMIO_BRIDGE -- requirements
Module: mips_mmio_bridge

---
 rtl/mips_mmio_bridge.sv | 181 ++++++++++++++++++
 tb/tb_mips_mmio_bridge.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mips_mmio_bridge.sv
// MIPS memory-mapped I/O bridge: RAM pass-through plus LED, cycle counter,
// and a 4-deep TX FIFO feeding an 8N1 UART transmitter at 0xFFFF_000x.
module mips_mmio_bridge #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        rstb,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wr_data,
    input  logic        mem_wr_ena,
    output logic [31:0] mem_rd_data,
    input  logic [31:0] ram_rd_data,
    output logic        ram_wr_ena,
    output logic [7:0]  leds,
    output logic        uart_tx
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    logic        mmio_hit, reg_ok;
    logic [1:0]  reg_sel;
    logic        wr_led, wr_cycle, wr_tx, wr_status;
    logic [31:0] cycle_cnt;

    logic [7:0]  fifo_mem [4];
    logic [1:0]  wr_ptr, rd_ptr;
    logic [2:0]  fifo_cnt;
    logic        full, empty, overflow, push, pop;

    tx_state_t   state, state_nx;
    logic [15:0] baud_cnt, baud_nx;
    logic [2:0]  bit_idx, bit_nx;
    logic [7:0]  shreg, shreg_nx;
    logic        tx_nx, busy, bit_end;

    logic        unused_ok;
    assign unused_ok = ^{mem_addr[1:0], mem_wr_data[31:8]};

    assign mmio_hit  = (mem_addr[31:16] == 16'hFFFF);
    assign reg_ok    = mmio_hit && (mem_addr[15:4] == 12'h000);
    assign reg_sel   = mem_addr[3:2];
    assign ram_wr_ena = mem_wr_ena & ~mmio_hit;

    assign wr_led    = mem_wr_ena && reg_ok && (reg_sel == 2'd0);
    assign wr_cycle  = mem_wr_ena && reg_ok && (reg_sel == 2'd1);
    assign wr_tx     = mem_wr_ena && reg_ok && (reg_sel == 2'd2);
    assign wr_status = mem_wr_ena && reg_ok && (reg_sel == 2'd3);

    assign full  = (fifo_cnt == 3'd4);
    assign empty = (fifo_cnt == 3'd0);
    assign push  = wr_tx && !full;
    assign busy  = (state != IDLE);

    always_comb begin
        mem_rd_data = '0;
        if (!mmio_hit) begin
            mem_rd_data = ram_rd_data;
        end else if (reg_ok) begin
            case (reg_sel)
                2'd0:    mem_rd_data = {24'b0, leds};
                2'd1:    mem_rd_data = cycle_cnt;
                2'd2:    mem_rd_data = '0;
                default: mem_rd_data = {25'b0, fifo_cnt, overflow, busy, empty, full};
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            leds      <= '0;
            cycle_cnt <= '0;
        end else begin
            if (wr_led) leds <= mem_wr_data[7:0];
            cycle_cnt <= wr_cycle ? '0 : cycle_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= mem_wr_data[7:0];
    end

    // Overflow is judged on the pre-edge full flag, so a same-cycle pop does not rescue the write.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (wr_tx && full)
                overflow <= 1'b1;
            else if (wr_status && mem_wr_data[3])
                overflow <= 1'b0;
        end
    end

    assign bit_end = (baud_cnt == BAUD_LAST);

    always_comb begin
        state_nx = state;
        baud_nx  = baud_cnt;
        bit_nx   = bit_idx;
        shreg_nx = shreg;
        tx_nx    = uart_tx;
        pop      = 1'b0;
        case (state)
            IDLE: begin
                tx_nx   = 1'b1;
                baud_nx = '0;
                if (!empty) begin
                    pop      = 1'b1;
                    shreg_nx = fifo_mem[rd_ptr];
                    state_nx = START;
                    tx_nx    = 1'b0;
                end
            end
            START: begin
                baud_nx = baud_cnt + 16'd1;
                if (bit_end) begin
                    baud_nx  = '0;
                    bit_nx   = '0;
                    state_nx = DATA;
                    tx_nx    = shreg[0];
                end
            end
            DATA: begin
                baud_nx = baud_cnt + 16'd1;
                if (bit_end) begin
                    baud_nx = '0;
                    if (bit_idx == 3'd7) begin
                        state_nx = STOP;
                        tx_nx    = 1'b1;
                    end else begin
                        bit_nx   = bit_idx + 3'd1;
                        shreg_nx = {1'b0, shreg[7:1]};
                        tx_nx    = shreg[1];
                    end
                end
            end
            STOP: begin
                baud_nx = baud_cnt + 16'd1;
                if (bit_end) begin
                    baud_nx  = '0;
                    state_nx = IDLE;
                    tx_nx    = 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                baud_nx  = '0;
                tx_nx    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            uart_tx  <= 1'b1;
        end else begin
            state    <= state_nx;
            baud_cnt <= baud_nx;
            bit_idx  <= bit_nx;
            shreg    <= shreg_nx;
            uart_tx  <= tx_nx;
        end
    end

endmodule

// File: tb/tb_mips_mmio_bridge.sv
// Directed bench for mips_mmio_bridge with CLKS_PER_BIT=4.
module tb_mips_mmio_bridge;

    localparam logic [31:0] A_LED    = 32'hFFFF_0000;
    localparam logic [31:0] A_CYCLE  = 32'hFFFF_0004;
    localparam logic [31:0] A_TX     = 32'hFFFF_0008;
    localparam logic [31:0] A_STATUS = 32'hFFFF_000C;

    logic        clk = 1'b0;
    logic        rstb;
    logic [31:0] mem_addr, mem_wr_data, mem_rd_data, ram_rd_data;
    logic        mem_wr_ena, ram_wr_ena, uart_tx;
    logic [7:0]  leds;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    mips_mmio_bridge #(.CLKS_PER_BIT(4)) dut (
        .clk(clk), .rstb(rstb),
        .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_wr_ena(mem_wr_ena),
        .mem_rd_data(mem_rd_data), .ram_rd_data(ram_rd_data), .ram_wr_ena(ram_wr_ena),
        .leds(leds), .uart_tx(uart_tx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the next negedge so calls chain back-to-back.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        mem_addr    = a;
        mem_wr_data = d;
        mem_wr_ena  = 1'b1;
        @(negedge clk);
        mem_wr_ena  = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        mem_addr = a;
        #1;
        check(tag, mem_rd_data, exp);
    endtask

    task automatic rx_frame(input string tag, input logic [7:0] exp);
        int unsigned t;
        logic [7:0]  b;
        t = 0;
        b = '0;
        while (uart_tx !== 1'b0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            repeat (2) @(negedge clk);
            check({tag, "_start"}, {31'b0, uart_tx}, 32'd0);
            for (int i = 0; i < 8; i++) begin
                repeat (4) @(negedge clk);
                b[i] = uart_tx;
            end
            repeat (4) @(negedge clk);
            check({tag, "_stop"}, {31'b0, uart_tx}, 32'd1);
            check(tag, {24'b0, b}, {24'b0, exp});
        end
    endtask

    initial begin
        logic [9:0] pat;
        logic       seen_low;

        rstb = 1'b0; mem_addr = '0; mem_wr_data = '0; mem_wr_ena = 1'b0; ram_rd_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_leds", {24'b0, leds}, 32'd0);
        check("rst_tx", {31'b0, uart_tx}, 32'd1);
        rd("rst_status", A_STATUS, 32'h2);
        rd("rst_cycle", A_CYCLE, 32'd0);
        mem_addr = 32'h40; mem_wr_ena = 1'b1;
        #1;
        check("rst_ram_we", {31'b0, ram_wr_ena}, 32'd1);
        mem_wr_ena = 1'b0;
        @(negedge clk);
        rstb = 1'b1;

        // LED register, address alias and unmapped window
        @(negedge clk);
        wr(A_LED, 32'h0000_01A5);
        check("led_q", {24'b0, leds}, 32'hA5);
        rd("led_rd", A_LED, 32'h0000_00A5);
        rd("led_alias", 32'hFFFF_0003, 32'h0000_00A5);
        @(negedge clk);
        wr(32'hFFFF_0010, 32'hFF);
        check("unmap_wr", {24'b0, leds}, 32'hA5);
        rd("unmap_rd", 32'hFFFF_0010, 32'd0);
        rd("txdata_rd", A_TX, 32'd0);

        // RAM pass-through
        @(negedge clk);
        mem_addr = 32'h0000_0040; mem_wr_ena = 1'b1; ram_rd_data = 32'hDEADBEEF;
        #1;
        check("ram_we", {31'b0, ram_wr_ena}, 32'd1);
        check("ram_rd", mem_rd_data, 32'hDEADBEEF);
        mem_addr = 32'hFFFF_0004;
        #1;
        check("mmio_we", {31'b0, ram_wr_ena}, 32'd0);
        mem_wr_ena = 1'b0;

        // Cycle counter clear and wrap
        @(negedge clk);
        wr(A_CYCLE, 32'h1234_5678);
        repeat (10) @(negedge clk);
        rd("cycle_10", A_CYCLE, 32'd10);
        @(negedge clk);
        force dut.cycle_cnt = 32'hFFFF_FFFF;
        rd("cycle_max", A_CYCLE, 32'hFFFF_FFFF);
        #1;
        release dut.cycle_cnt;
        @(negedge clk);
        rd("cycle_wrap", A_CYCLE, 32'd0);
        @(negedge clk);
        rd("cycle_after", A_CYCLE, 32'd1);

        // Single byte 0x55: ten bits of four cycles each
        pat = 10'b1_0101_0101_0;
        @(negedge clk);
        wr(A_TX, 32'h55);
        mem_addr = A_STATUS;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            check($sformatf("tx55_c%0d", k), {31'b0, uart_tx}, {31'b0, pat[k/4]});
            if (k == 0 || k == 39) check($sformatf("tx55_st%0d", k), mem_rd_data, 32'h6);
        end
        @(negedge clk);
        check("tx55_idle", {31'b0, uart_tx}, 32'd1);
        check("tx55_done", mem_rd_data, 32'h2);

        // Overflow: 0x01 popped, 0x02..0x05 queued, 0x06 dropped
        repeat (3) @(negedge clk);
        fork
            begin
                for (int i = 1; i <= 6; i++) wr(A_TX, i);
                rd("ovf_status", A_STATUS, 32'h4D);
                @(negedge clk);
                wr(A_STATUS, 32'h8);
                rd("ovf_clear", A_STATUS, 32'h45);
            end
            begin
                for (int i = 1; i <= 5; i++) rx_frame($sformatf("ovf_frame%0d", i), 8'(i));
            end
        join
        repeat (10) @(negedge clk);
        rd("ovf_drained", A_STATUS, 32'h2);

        // Reset during data bit 3 with two bytes queued
        @(negedge clk);
        wr(A_TX, 32'hF7);
        wr(A_TX, 32'h11);
        wr(A_TX, 32'h22);
        repeat (16) @(negedge clk);
        check("mid_bit3", {31'b0, uart_tx}, 32'd0);
        rd("mid_status", A_STATUS, 32'h24);
        rstb = 1'b0;
        @(negedge clk);
        check("mid_rst_tx", {31'b0, uart_tx}, 32'd1);
        rd("mid_rst_status", A_STATUS, 32'h2);
        rstb = 1'b1;
        seen_low = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) seen_low = 1'b1;
        end
        check("mid_no_frames", {31'b0, seen_low}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
